// File: rtl/fc_param_reader.sv
// Streams one dense layer's parameters (bias, then N_IN weights, per neuron) from the
// bias/weight RAMs to the MAC datapath, absorbing RAM read latency and downstream backpressure.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing RAM reads, one per cycle while credit allows
// DRAIN | all reads issued; waiting for the last beat to leave
module fc_param_reader #(
  parameter int DATA_W   = 16,
  parameter int N_IN     = 120,
  parameter int N_OUT    = 84,
  parameter int W_ADDR_W = 14,
  parameter int B_ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                w_rd_en,
  output logic [W_ADDR_W-1:0] w_rd_addr,
  input  logic [DATA_W-1:0]   w_rd_data,
  output logic                b_rd_en,
  output logic [B_ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0]   b_rd_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_is_bias,
  output logic [B_ADDR_W-1:0] out_neuron,
  output logic                out_last_neuron,
  output logic                out_last
);

  localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [I_W-1:0]      I_LAST = I_W'(N_IN - 1);
  localparam logic [B_ADDR_W-1:0] J_LAST = B_ADDR_W'(N_OUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic                is_bias;
    logic [B_ADDR_W-1:0] neuron;
    logic                last_neuron;
    logic                last;
  } beat_t;

  state_t              state_q, state_d;
  logic [B_ADDR_W-1:0] j_q, j_d;
  logic [I_W-1:0]      i_q, i_d;
  logic                bias_slot_q, bias_slot_d;
  logic [W_ADDR_W-1:0] w_addr_q, w_addr_d;

  logic                fl_vld_q;
  logic                fl_bias_q;
  logic [B_ADDR_W-1:0] fl_neuron_q;
  logic                fl_last_neuron_q;
  logic                fl_last_q;

  beat_t               fifo_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          count_q;

  logic                pop, push, issue, is_last_w;
  logic [1:0]          credit_used;
  beat_t               push_beat, head;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign push      = fl_vld_q;
  // A pop this cycle frees its slot in time for the next push, which keeps 1 beat/cycle.
  assign credit_used = count_q + {1'b0, fl_vld_q} - {1'b0, pop};
  assign issue       = (state_q == S_RUN) && (credit_used < 2'd2);
  assign is_last_w   = !bias_slot_q && (i_q == I_LAST);

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    i_d         = i_q;
    bias_slot_d = bias_slot_q;
    w_addr_d    = w_addr_q;
    b_rd_en     = 1'b0;
    w_rd_en     = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          j_d         = '0;
          i_d         = '0;
          bias_slot_d = 1'b1;
          w_addr_d    = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (bias_slot_q) begin
            b_rd_en     = 1'b1;
            bias_slot_d = 1'b0;
            i_d         = '0;
          end else begin
            w_rd_en  = 1'b1;
            w_addr_d = w_addr_q + W_ADDR_W'(1);
            if (i_q == I_LAST) begin
              i_d         = '0;
              bias_slot_d = 1'b1;
              j_d         = j_q + B_ADDR_W'(1);
              if (j_q == J_LAST) state_d = S_DRAIN;
            end else begin
              i_d = i_q + I_W'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (!fl_vld_q && (count_q == 2'd0)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign b_rd_addr = b_rd_en ? j_q : '0;
  assign w_rd_addr = w_rd_en ? w_addr_q : '0;

  always_comb begin
    push_beat.data        = fl_bias_q ? b_rd_data : w_rd_data;
    push_beat.is_bias     = fl_bias_q;
    push_beat.neuron      = fl_neuron_q;
    push_beat.last_neuron = fl_last_neuron_q;
    push_beat.last        = fl_last_q;
  end

  assign head            = fifo_q[rd_ptr_q];
  assign out_data        = out_valid ? head.data : '0;
  assign out_is_bias     = out_valid && head.is_bias;
  assign out_neuron      = out_valid ? head.neuron : '0;
  assign out_last_neuron = out_valid && head.last_neuron;
  assign out_last        = out_valid && head.last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      j_q              <= '0;
      i_q              <= '0;
      bias_slot_q      <= 1'b0;
      w_addr_q         <= '0;
      fl_vld_q         <= 1'b0;
      fl_bias_q        <= 1'b0;
      fl_neuron_q      <= '0;
      fl_last_neuron_q <= 1'b0;
      fl_last_q        <= 1'b0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
      for (int k = 0; k < 2; k++) fifo_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      i_q         <= i_d;
      bias_slot_q <= bias_slot_d;
      w_addr_q    <= w_addr_d;
      fl_vld_q    <= issue;
      if (issue) begin
        fl_bias_q        <= bias_slot_q;
        fl_neuron_q      <= j_q;
        fl_last_neuron_q <= is_last_w;
        fl_last_q        <= is_last_w && (j_q == J_LAST);
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= push_beat;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fc_param_reader.sv
// Directed bench for fc_param_reader on a 2-neuron x 3-input layer with behavioural RAMs.
module tb_fc_param_reader;

  localparam int DW  = 16;
  localparam int NI  = 3;
  localparam int NO  = 2;
  localparam int WAW = 3;
  localparam int BAW = 2;
  localparam int NB  = NO * (NI + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           out_ready = 1'b0;
  logic           busy, done, w_rd_en, b_rd_en;
  logic [WAW-1:0] w_rd_addr;
  logic [BAW-1:0] b_rd_addr;
  logic [DW-1:0]  w_rd_data = '0;
  logic [DW-1:0]  b_rd_data = '0;
  logic           out_valid, out_is_bias, out_last_neuron, out_last;
  logic [DW-1:0]  out_data;
  logic [BAW-1:0] out_neuron;

  logic [DW-1:0] bmem [NO];
  logic [DW-1:0] wmem [NO*NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fc_param_reader #(
    .DATA_W(DW), .N_IN(NI), .N_OUT(NO), .W_ADDR_W(WAW), .B_ADDR_W(BAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_is_bias(out_is_bias), .out_neuron(out_neuron),
    .out_last_neuron(out_last_neuron), .out_last(out_last)
  );

  always @(posedge clk) begin
    if (b_rd_en) b_rd_data <= bmem[int'(b_rd_addr) % NO];
    if (w_rd_en) w_rd_data <= wmem[int'(w_rd_addr) % (NO*NI)];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int k);
    int n;
    int p;
    n = k / (NI + 1);
    p = k % (NI + 1);
    if (p == 0) return bmem[n];
    return wmem[n*NI + p - 1];
  endfunction

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      1: return (c % 4 == 0) || (c % 4 == 3);
      2: return c > 10;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_wen"},   w_rd_en, 0);
    chk({tag, "_waddr"}, w_rd_addr, 0);
    chk({tag, "_ben"},   b_rd_en, 0);
    chk({tag, "_baddr"}, b_rd_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_tags"},  {out_is_bias, out_neuron, out_last_neuron, out_last}, 0);
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: ready low through cycle 10;
  // 3: ready high with start re-pulsed in RUN, DRAIN and the done cycle.
  task automatic run_pass(input int mode, input int abort_after);
    int acc = 0;
    int iss = 0;
    int dones = 0;
    int last_c = -10;
    logic prev_stall = 1'b0;
    logic [DW-1:0] h_data = '0;
    logic [4:0] h_tags = '0;
    int n;
    int p;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = rdy(mode, 0);
    @(negedge clk);
    for (int c = 1; c < 200; c++) begin
      @(posedge clk); #1;
      start = (mode == 3) && (c == 4 || c == 9 || c == last_c + 1);
      out_ready = rdy(mode, c);
      @(negedge clk);
      if (c == 1) chk("busy_run", busy, 1);
      if (c == 2) chk("valid_c2", out_valid, 0);
      if (c == 3) chk("valid_c3", out_valid, 1);
      if (b_rd_en || w_rd_en) begin
        chk("one_en", b_rd_en && w_rd_en, 0);
        n = iss / (NI + 1);
        p = iss % (NI + 1);
        if (p == 0) begin
          chk("b_en", b_rd_en, 1);
          chk("b_addr", b_rd_addr, n);
        end else begin
          chk("w_en", w_rd_en, 1);
          chk("w_addr", w_rd_addr, n*NI + p - 1);
        end
        iss++;
      end
      if (mode == 2 && c == 10) begin
        chk("stall_reads", iss, 2);
        chk("stall_head", out_data, bmem[0]);
        chk("stall_bias", out_is_bias, 1);
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, h_data);
        chk("hold_tags", {out_is_bias, out_neuron, out_last_neuron, out_last}, h_tags);
      end
      if (out_valid && out_ready) begin
        n = acc / (NI + 1);
        p = acc % (NI + 1);
        chk("beat_data", out_data, exp_data(acc));
        chk("beat_tags", {out_is_bias, out_neuron, out_last_neuron, out_last},
            {p == 0, BAW'(n), p == NI, acc == NB - 1});
        acc++;
        if (acc == NB) last_c = c;
      end
      prev_stall = out_valid && !out_ready;
      h_data = out_data;
      h_tags = {out_is_bias, out_neuron, out_last_neuron, out_last};
      if (done) begin
        dones++;
        chk("done_time", c, last_c + 1);
      end
      if (abort_after > 0 && acc == abort_after) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_idle", busy, 0);
        end
        return;
      end
      if (dones > 0 && c >= last_c + 2) begin
        chk("busy_after", busy, 0);
        break;
      end
    end
    chk("beats", acc, NB);
    chk("reads", iss, NB);
    chk("dones", dones, 1);
    if (mode == 0) chk("throughput", last_c, NB + 2);
  endtask

  initial begin
    for (int k = 0; k < NO; k++) bmem[k] = DW'(16'hA000 + k);
    for (int k = 0; k < NO*NI; k++) wmem[k] = DW'(16'h1000 + 16'h0111 * k);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");
    run_pass(0, 0);
    run_pass(1, 0);
    run_pass(0, 5);
    run_pass(0, 0);
    run_pass(3, 0);
    run_pass(2, 0);
    for (int k = 0; k < 16; k++) wmem[k % (NO*NI)] = DW'($urandom_range(0, 65535));
    bmem[0] = 16'h8001;
    bmem[1] = 16'h7FFE;
    run_pass(1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_param_reader.md
Name: fc_param_reader

Overview:
- Read-side counterpart of the FC parameter memories: walks the bias and weight RAMs of one dense layer and streams the parameters to the MAC datapath.
- Stream order is neuron-major. For each output neuron j, the bias is sent first, then its N_IN weights.
- Sits between the parameter RAMs (loaded from the Bin parameter files) and the FC accumulator.
- Handles the 1-cycle RAM read latency and downstream backpressure without losing or duplicating beats.

Parameters:
- DATA_W, 16, parameter word width (fixed-point, as stored in the files).
- N_IN, 120, inputs per neuron (weights per neuron).
- N_OUT, 84, output neurons (bias entries).
- W_ADDR_W, 14, weight RAM address width; must satisfy 2^W_ADDR_W >= N_IN*N_OUT.
- B_ADDR_W, 7, bias RAM address width and out_neuron width; must satisfy 2^B_ADDR_W >= N_OUT.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a full pass.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- w_rd_en  out  1  weight RAM read enable.
- w_rd_addr  out  W_ADDR_W  weight address, j*N_IN+i.
- w_rd_data  in  DATA_W  weight data, valid 1 cycle after w_rd_en.
- b_rd_en  out  1  bias RAM read enable.
- b_rd_addr  out  B_ADDR_W  bias address j.
- b_rd_data  in  DATA_W  bias data, valid 1 cycle after b_rd_en.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  bias or weight word.
- out_is_bias  out  1  beat is the bias of out_neuron.
- out_neuron  out  B_ADDR_W  neuron index j of the beat.
- out_last_neuron  out  1  beat is weight N_IN-1 of its neuron.
- out_last  out  1  final beat of the pass (last weight of neuron N_OUT-1).

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; all counters cleared; FIFO emptied; in-flight read discarded. All outputs are 0.
- Reset mid-pass aborts the pass with no done pulse.
- States and transitions:
  - IDLE: on start, go to RUN; j=0, i=-1, where i=-1 means the bias slot.
  - RUN: issue one read per cycle while the credit rule permits. When the issue pointer passes (N_OUT-1, N_IN-1), go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty and the last beat is accepted. Then pulse done and go to IDLE.
- Issue sequence per neuron:
  - Bias read: b_rd_en=1, b_rd_addr=j.
  - Then N_IN weight reads: w_rd_en=1, w_rd_addr=j*N_IN+i, i=0..N_IN-1.
  - The weight address is kept as an incrementing counter (no multiplier); it runs 0..N_IN*N_OUT-1 continuously.
  - Never more than one read enable asserted per cycle.
- Read latency: returned data plus tags (is_bias, neuron, last_neuron, last) are pushed into a 2-entry output FIFO on the cycle after issue.
- Credit rule: issue only if FIFO occupancy + in-flight reads < 2. Full throughput (1 beat/cycle) is sustained while out_ready is held high.
- First beat latency: out_valid is first asserted 2 cycles after the start edge.
- Output handshake:
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and all tags are held stable.
  - out_valid never drops without a transfer.
- Simultaneous FIFO push and pop at occupancy 2 cannot occur, because the credit rule prevents it.
- Push and pop in the same cycle at occupancy 1 keeps occupancy at 1.
- start while busy is ignored. start in the same cycle as done is ignored.
- Total beats per pass: N_OUT*(N_IN+1), which is 10164 at defaults. Exactly one beat per pass has out_last=1.
- No arithmetic on the data; words pass through bit-exact.

Test Plan:
- N_IN=3, N_OUT=2, RAMs pre-loaded (bias {A0,A1}, weights W0..W5), out_ready=1, start pulse.
  -> Beats in order A0,W0,W1,W2,A1,W3,W4,W5.
  -> out_is_bias on beats 0 and 4; out_last_neuron on W2 and W5; out_last on W5 only.
  -> First out_valid 2 cycles after start; done 1 cycle after W5 accepted.
- Same setup, out_ready toggled 1,0,0,1 repeating.
  -> Identical 8-beat sequence, no drops or duplicates; data held stable across every stalled cycle.
- Default params with the Bin files loaded, random out_ready.
  -> 10164 beats; beat k of neuron j equals Layer W[j*120+k-1]; busy falls with done.
- rst_n low for 1 cycle after 5 accepted beats.
  -> Next cycle all outputs 0, no done.
  -> A new start restarts from bias 0.
- start re-pulsed during RUN.
  -> Ignored: beat count unchanged, exactly one done.
- out_ready=0 from start for 10 cycles.
  -> At most 2 reads issued; out_valid=1 showing A0.
  -> Stream resumes correctly when out_ready=1.
